// File: rtl/cmos_axis_pkg.sv
// cmos_axis_pkg
//   Shared types and constants for the CMOS video to AXI4-Stream bridge.
//   - state_t      : capture FSM states (IDLE, ACTIVE, DROP)
//   - ENTRY_TAG_W  : sideband bits carried per FIFO entry (tuser, tlast)
//   - TLAST_OFS / TUSER_OFS : sideband bit offsets above the pixel field
//   - entry_w()    : FIFO entry width for a given pixel width (DATA_W+2)
package cmos_axis_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DROP
  } state_t;

  localparam int unsigned ENTRY_TAG_W = 2;
  localparam int unsigned TLAST_OFS   = 0;
  localparam int unsigned TUSER_OFS   = 1;

  function automatic int unsigned entry_w(input int unsigned data_w);
    return data_w + ENTRY_TAG_W;
  endfunction

endpackage

// File: rtl/cmos_axis_fifo.sv
// cmos_axis_fifo
//   Synchronous first-word-fall-through FIFO.
//   Ports:
//     i_clk, i_rst       clock, synchronous active-high reset
//     i_push, i_din      write request and data (ignored when full unless a pop
//                        happens in the same cycle)
//     i_pop              read request (ignored when empty)
//     o_dout             head entry, valid while !o_empty; forced 0 when empty
//     o_full, o_empty    status from the registered (pre-pop) count
module cmos_axis_fifo #(
  parameter int unsigned WIDTH = 26,
  parameter int unsigned DEPTH = 1024
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_wr;
  logic             w_rd;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == CNT_W'(DEPTH));
  assign w_rd    = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_wr    = i_push & (~o_full | w_rd);
  assign o_dout  = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_rd) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/cmos_video_to_axis.sv
// cmos_video_to_axis
//   Converts the gated RGB888 capture stream (cam_pclk domain) into
//   AXI4-Stream video. tuser marks the first pixel of a frame, tlast the last
//   pixel of a line. A one-pixel hold register delays each pixel until the
//   next pixel or end of line so tlast can be attached after the fact.
//   Backpressure is absorbed in a FIFO; a frame that overflows it is dropped
//   up to the next vsync.
//   Ports:
//     cam_pclk, rst                     clock, synchronous active-high reset
//     cmos_frame_ce/vsync/active_video  capture controls
//     cmos_frame_data                   pixel
//     m_axis_video_*                    AXI4-Stream master
//     fifo_overflow                     sticky, pixel lost to a full FIFO
//     frame_cnt                         frames started, wraps
//     line_err                          sticky line-length error
//   Build option: CMOS_LINE_CHECK_EN enables the per-line pixel count check
//   against H_ACTIVE; without it line_err is tied 0.
module cmos_video_to_axis
  import cmos_axis_pkg::*;
#(
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned FIFO_DEPTH = 1024,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned LCNT_W     = 12
) (
  input  logic              cam_pclk,
  input  logic              rst,
  input  logic              cmos_frame_ce,
  input  logic              cmos_frame_vsync,
  input  logic              cmos_active_video,
  input  logic [DATA_W-1:0] cmos_frame_data,
  output logic [DATA_W-1:0] m_axis_video_tdata,
  output logic              m_axis_video_tvalid,
  input  logic              m_axis_video_tready,
  output logic              m_axis_video_tuser,
  output logic              m_axis_video_tlast,
  output logic              fifo_overflow,
  output logic [15:0]       frame_cnt,
  output logic              line_err
);

  localparam int unsigned ENTRY_W = entry_w(DATA_W);

  if ((FIFO_DEPTH < 16) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
      || (H_ACTIVE >= (1 << LCNT_W))) begin : g_bad_cfg
    $error("cmos_video_to_axis: invalid FIFO_DEPTH / H_ACTIVE / LCNT_W");
  end

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_vs_d;
  logic                r_av_d;
  logic                r_hold_vld;
  logic                w_hold_vld_nxt;
  logic                w_hold_load;
  logic [DATA_W-1:0]   r_hold_data;
  logic                r_sof_pend;
  logic                w_sof_pend_nxt;
  logic [15:0]         r_frame_cnt;
  logic                w_frame_inc;
  logic                r_overflow;
  logic                w_ovf_set;
  logic                w_line_bad;
  logic                w_pix;
  logic                w_vs_rise;
  logic                w_av_fall;
  logic                w_push;
  logic                w_push_last;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic                w_blocked;
  logic [ENTRY_W-1:0]  w_push_entry;
  logic [ENTRY_W-1:0]  w_pop_entry;

  assign w_pix     = cmos_frame_ce & cmos_active_video & ~cmos_frame_vsync;
  assign w_vs_rise = cmos_frame_vsync & ~r_vs_d;
  assign w_av_fall = ~cmos_active_video & r_av_d;
  assign w_pop     = ~w_empty & m_axis_video_tready;
  assign w_blocked = w_full & ~w_pop;

  assign w_push_entry = {r_sof_pend, w_push_last, r_hold_data};

  always_comb begin
    w_state_nxt    = r_state;
    w_push         = 1'b0;
    w_push_last    = 1'b0;
    w_hold_vld_nxt = r_hold_vld;
    w_hold_load    = 1'b0;
    w_sof_pend_nxt = r_sof_pend;
    w_frame_inc    = 1'b0;
    w_ovf_set      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_vs_rise) begin
          w_state_nxt    = ST_ACTIVE;
          w_sof_pend_nxt = 1'b1;
          w_frame_inc    = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (w_vs_rise) begin
          // Truncated line: the held pixel closes the old frame's line. A
          // failed flush only loses that pixel; the new frame still starts.
          w_push         = r_hold_vld;
          w_push_last    = 1'b1;
          w_ovf_set      = r_hold_vld & w_blocked;
          w_hold_vld_nxt = 1'b0;
          w_sof_pend_nxt = 1'b1;
          w_frame_inc    = 1'b1;
        end else if (w_pix) begin
          w_push = r_hold_vld;
          if (r_hold_vld && w_blocked) begin
            w_ovf_set      = 1'b1;
            w_hold_vld_nxt = 1'b0;
            w_state_nxt    = ST_DROP;
          end else begin
            w_hold_load    = 1'b1;
            w_hold_vld_nxt = 1'b1;
            if (r_hold_vld) begin
              w_sof_pend_nxt = 1'b0;
            end
          end
        end else if (w_av_fall && r_hold_vld) begin
          // Only lines that delivered pixels are length-checked.
          w_push         = 1'b1;
          w_push_last    = 1'b1;
          w_hold_vld_nxt = 1'b0;
          if (w_blocked) begin
            w_ovf_set   = 1'b1;
            w_state_nxt = ST_DROP;
          end else begin
            w_sof_pend_nxt = 1'b0;
          end
          if (w_line_bad) begin
            w_state_nxt = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        w_hold_vld_nxt = 1'b0;
        if (w_vs_rise) begin
          w_state_nxt    = ST_ACTIVE;
          w_sof_pend_nxt = 1'b1;
          w_frame_inc    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge cam_pclk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_vs_d      <= 1'b0;
      r_av_d      <= 1'b0;
      r_hold_vld  <= 1'b0;
      r_hold_data <= '0;
      r_sof_pend  <= 1'b0;
      r_frame_cnt <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_vs_d     <= cmos_frame_vsync;
      r_av_d     <= cmos_active_video;
      r_hold_vld <= w_hold_vld_nxt;
      if (w_hold_load) begin
        r_hold_data <= cmos_frame_data;
      end
      r_sof_pend <= w_sof_pend_nxt;
      if (w_frame_inc) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      r_overflow <= r_overflow | w_ovf_set;
    end
  end

`ifdef CMOS_LINE_CHECK_EN
  logic [LCNT_W-1:0] r_lcnt;
  logic              r_line_err;

  assign w_line_bad = (r_lcnt != LCNT_W'(H_ACTIVE));

  always_ff @(posedge cam_pclk) begin
    if (rst) begin
      r_lcnt     <= '0;
      r_line_err <= 1'b0;
    end else begin
      if (w_vs_rise || w_av_fall) begin
        r_lcnt <= '0;
      end else if (w_pix) begin
        r_lcnt <= r_lcnt + 1'b1;
      end
      // End-of-line push in ACTIVE is the only push with tlast and no vs_rise.
      if (w_push && w_push_last && !w_vs_rise && w_line_bad) begin
        r_line_err <= 1'b1;
      end
    end
  end

  assign line_err = r_line_err;
`else
  assign w_line_bad = 1'b0;
  assign line_err   = 1'b0;
`endif

  cmos_axis_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (cam_pclk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_din   (w_push_entry),
    .i_pop   (m_axis_video_tready),
    .o_dout  (w_pop_entry),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign m_axis_video_tvalid = ~w_empty;
  assign m_axis_video_tdata  = w_pop_entry[DATA_W-1:0];
  assign m_axis_video_tlast  = w_pop_entry[DATA_W + TLAST_OFS];
  assign m_axis_video_tuser  = w_pop_entry[DATA_W + TUSER_OFS];
  assign fifo_overflow       = r_overflow;
  assign frame_cnt           = r_frame_cnt;

endmodule

// File: tb/tb_cmos_video_to_axis.sv
// tb_cmos_video_to_axis
//   Frame-level reference model: each frame is described as a list of line
//   lengths plus pixel values; the expected beat list is derived from that
//   description (tuser on the first beat, tlast on each line's last pixel,
//   truncated to the FIFO depth for a fully stalled frame, cut after the first
//   bad line when the line check is built in). A negedge monitor compares every
//   presented beat, stalled or accepted, against the head of that list.
module tb_cmos_video_to_axis;

  localparam int unsigned DW    = 24;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned H_ACT = 8;
`ifdef CMOS_LINE_CHECK_EN
  localparam bit LINE_CHK = 1'b1;
`else
  localparam bit LINE_CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic          vsync;
  logic          active;
  logic [DW-1:0] data;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tuser;
  logic          tlast;
  logic          ovf;
  logic [15:0]   fcnt;
  logic          lerr;

  always #5 clk = ~clk;

  cmos_video_to_axis #(
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH),
    .H_ACTIVE   (H_ACT),
    .LCNT_W     (12)
  ) dut (
    .cam_pclk            (clk),
    .rst                 (rst),
    .cmos_frame_ce       (ce),
    .cmos_frame_vsync    (vsync),
    .cmos_active_video   (active),
    .cmos_frame_data     (data),
    .m_axis_video_tdata  (tdata),
    .m_axis_video_tvalid (tvalid),
    .m_axis_video_tready (tready),
    .m_axis_video_tuser  (tuser),
    .m_axis_video_tlast  (tlast),
    .fifo_overflow       (ovf),
    .frame_cnt           (fcnt),
    .line_err            (lerr)
  );

  int unsigned   n_checks = 0;
  int unsigned   n_errors = 0;
  int unsigned   n_beats  = 0;
  int unsigned   exp_total = 0;
  int unsigned   frames_sent = 0;
  int unsigned   seq = 1;
  int unsigned   rdy_mode = 1;  // 0: low, 1: high, 2: random
  bit            mon_en = 1'b0;
  bit            exp_lerr = 1'b0;
  logic [DW+1:0] exp_q[$];
  int unsigned   line_len[$];
  logic [DW-1:0] pix_q[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tready = 1'b1;
    forever begin
      tick();
      case (rdy_mode)
        0:       tready = 1'b0;
        1:       tready = 1'b1;
        default: tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (mon_en && tvalid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_tvalid", 64'(tvalid), 64'd0);
      end else begin
        chk(tready ? "beat" : "stall_hold", {tuser, tlast, tdata}, exp_q[0]);
        if (tready) begin
          void'(exp_q.pop_front());
          n_beats++;
        end
      end
    end
  end

  task automatic fill_pix(input bit rnd);
    int unsigned total = 0;
    pix_q.delete();
    foreach (line_len[i]) total += line_len[i];
    for (int unsigned i = 0; i < total; i++) begin
      pix_q.push_back(rnd ? DW'($urandom) : DW'(seq));
      seq++;
    end
  endtask

  task automatic set_frame(input int unsigned nlines, input int unsigned len, input bit rnd);
    line_len.delete();
    for (int unsigned l = 0; l < nlines; l++) line_len.push_back(len);
    fill_pix(rnd);
  endtask

  task automatic model_frame(input bit cut, input int unsigned cap);
    int unsigned idx = 0;
    int unsigned n = 0;
    logic        first = 1'b1;
    logic        last_b;
    for (int unsigned l = 0; l < line_len.size(); l++) begin
      for (int unsigned p = 0; p < line_len[l]; p++) begin
        last_b = (p == line_len[l] - 1);
        if (n < cap) begin
          exp_q.push_back({first, last_b, pix_q[idx]});
          exp_total++;
        end
        first = 1'b0;
        n++;
        idx++;
      end
      if (LINE_CHK && line_len[l] != H_ACT && !(cut && l == line_len.size() - 1)) begin
        exp_lerr = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_frame(input bit cut, input int unsigned cap, input bit rnd_ce);
    int unsigned idx = 0;
    int unsigned gap;
    model_frame(cut, cap);
    tick(); vsync = 1'b1; ce = 1'b0;
    tick(); active = 1'b0;
    tick(); tick(); vsync = 1'b0;
    tick(); tick();
    for (int unsigned l = 0; l < line_len.size(); l++) begin
      active = 1'b1;
      for (int unsigned p = 0; p < line_len[l]; p++) begin
        gap = rnd_ce ? $urandom_range(0, 2) : 1;
        repeat (gap) begin
          ce = 1'b0;
          tick();
        end
        ce = 1'b1;
        data = pix_q[idx];
        idx++;
        tick();
      end
      ce = 1'b0;
      if (!(cut && l == line_len.size() - 1)) begin
        active = 1'b0;
        tick(); tick(); tick();
      end
    end
    frames_sent++;
  endtask

  task automatic drain(input string tag);
    int unsigned t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      tick();
      t++;
    end
    repeat (4) tick();
    chk({tag, "_left"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_beats"}, 64'(n_beats), 64'(exp_total));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected completion before timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ce = 1'b0; vsync = 1'b0; active = 1'b0; data = '0;
    repeat (5) tick();
    rst = 1'b0;
    tick();
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tdata", 64'(tdata), 64'd0);
    chk("rst_tuser", 64'(tuser), 64'd0);
    chk("rst_tlast", 64'(tlast), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_fcnt", 64'(fcnt), 64'd0);
    chk("rst_lerr", 64'(lerr), 64'd0);
    mon_en = 1'b1;

    // two 4x8 frames, always ready
    rdy_mode = 1;
    for (int f = 0; f < 2; f++) begin
      set_frame(4, 8, 1'b0);
      run_frame(1'b0, 1000, 1'b0);
    end
    drain("two_frames");
    chk("two_frames_fcnt", 64'(fcnt), 64'(frames_sent));

    // pixels 1..8 with ce on every other cycle
    seq = 1;
    set_frame(1, 8, 1'b0);
    run_frame(1'b0, 1000, 1'b0);
    drain("ce_toggle");

    // fully stalled 4x8 frame overflows a 16-deep FIFO
    chk("pre_ovf", 64'(ovf), 64'd0);
    rdy_mode = 0;
    set_frame(4, 8, 1'b1);
    run_frame(1'b0, DEPTH, 1'b0);
    chk("ovf_set", 64'(ovf), 64'd1);
    rdy_mode = 1;
    drain("overflow");

    // random backpressure and pixel gaps
    rdy_mode = 2;
    for (int f = 0; f < 3; f++) begin
      set_frame(2, 8, 1'b1);
      run_frame(1'b0, 1000, 1'b1);
      drain("rand_bp");
    end
    chk("rand_fcnt", 64'(fcnt), 64'(frames_sent));

    // vsync arrives mid-line after 5 pixels
    rdy_mode = 1;
    line_len = {8, 5};
    fill_pix(1'b1);
    run_frame(1'b1, 1000, 1'b1);
    set_frame(2, 8, 1'b1);
    run_frame(1'b0, 1000, 1'b0);
    drain("trunc");
    chk("trunc_lerr", 64'(lerr), 64'd0);

    // short line in the middle of a frame
    line_len = {8, 7, 8, 8};
    fill_pix(1'b1);
    run_frame(1'b0, 1000, 1'b1);
    drain("short_line");
    chk("short_lerr", 64'(lerr), 64'(exp_lerr));
    set_frame(1, 8, 1'b1);
    run_frame(1'b0, 1000, 1'b0);
    drain("after_short");

    chk("end_ovf", 64'(ovf), 64'd1);
    chk("end_lerr", 64'(lerr), 64'(exp_lerr));
    chk("end_fcnt", 64'(fcnt), 64'(frames_sent));
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
